// File: rtl/qmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// qmem_arb_pkg
//   Shared definitions for the QMEM N-master arbiter.
//   - arb_state_t : arbiter FSM state encoding (ST_IDLE / ST_BUSY)
//   - QMEM_AW/SW/DW : default QMEM address, byte-select and data widths
//   - QMEM_MN_MAX  : largest supported master count
// -----------------------------------------------------------------------------
package qmem_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   localparam int QMEM_AW     = 22;
   localparam int QMEM_SW     = 4;
   localparam int QMEM_DW     = 32;
   localparam int QMEM_MN_MAX = 8;

endpackage : qmem_arb_pkg

// File: rtl/qmem_arb_pick.sv
// -----------------------------------------------------------------------------
// qmem_arb_pick
//   Purely combinational winner picker for the QMEM arbiter.
//   Ports:
//     req    in  MN  masked request vector
//     last   in  GW  index of the last master that completed a transfer
//     rr_en  in  1   1: round-robin search from last+1, 0: lowest index wins
//     winner out GW  selected master index (0 when no request)
//     valid  out 1   at least one request present
// -----------------------------------------------------------------------------
module qmem_arb_pick
   import qmem_arb_pkg::*;
#(
   parameter int MN = 4,
   parameter int GW = 2
) (
   input  logic [MN-1:0] req,
   input  logic [GW-1:0] last,
   input  logic          rr_en,
   output logic [GW-1:0] winner,
   output logic          valid
);

   // Request vector padded to a power of two so any GW-bit index is legal.
   localparam int NP = 1 << GW;

   logic [NP-1:0] req_pad;

   always_comb begin
      req_pad         = '0;
      req_pad[MN-1:0] = req;
   end

   always_comb begin
      int          idx;
      logic        found;
      logic [GW-1:0] idx_g;

      idx    = 0;
      idx_g  = '0;
      found  = 1'b0;
      winner = '0;
      valid  = |req;

      if (rr_en) begin
         // Walk last+1, last+2, ... wrapping at MN so that padding indices
         // of a non power-of-two master count are never visited.
         for (int k = 1; k <= MN; k++) begin
            idx = int'(last) + k;
            if (idx >= MN) begin
               idx = idx - MN;
            end
            idx_g = GW'(idx);
            if (!found && req_pad[idx_g]) begin
               winner = idx_g;
               found  = 1'b1;
            end
         end
      end else begin
         // Scan downwards so the lowest requesting index is written last.
         for (int k = MN - 1; k >= 0; k--) begin
            idx_g = GW'(k);
            if (req_pad[idx_g]) begin
               winner = idx_g;
            end
         end
      end
   end

endmodule : qmem_arb_pick

// File: rtl/qmem_arbiter.sv
// -----------------------------------------------------------------------------
// qmem_arbiter
//   Shares one QMEM slave port between MN (2..8) masters. A grant is held
//   from request until the slave returns ack or err; one idle cycle follows
//   every transfer. Fixed priority (lowest index wins) by default.
//
//   Build option:
//     QMEM_ARB_RR_EN  defined -> round-robin arbitration, search starts at
//                                (last + 1) mod MN.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     m_cs/m_we     in  MN     per-master request / write enable
//     m_adr         in  MN*AW  flattened addresses, master i at [i*AW +: AW]
//     m_sel         in  MN*SW  flattened byte selects
//     m_dat_w       in  MN*DW  flattened write data
//     m_dat_r       out DW     read data broadcast to all masters
//     m_ack/m_err   out MN     per-master response strobes
//     s_cs/s_we/s_adr/s_sel/s_dat_w  out  slave request
//     s_dat_r/s_ack/s_err            in   slave response
//     gnt           out GW     current grant index (debug)
//     busy          out 1      transfer in progress
// -----------------------------------------------------------------------------
module qmem_arbiter
   import qmem_arb_pkg::*;
#(
   parameter int MN = 4,
   parameter int AW = QMEM_AW,
   parameter int SW = QMEM_SW,
   parameter int DW = QMEM_DW,
   parameter int GW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [MN-1:0]    m_cs,
   input  logic [MN-1:0]    m_we,
   input  logic [MN*AW-1:0] m_adr,
   input  logic [MN*SW-1:0] m_sel,
   input  logic [MN*DW-1:0] m_dat_w,
   output logic [DW-1:0]    m_dat_r,
   output logic [MN-1:0]    m_ack,
   output logic [MN-1:0]    m_err,
   output logic             s_cs,
   output logic             s_we,
   output logic [AW-1:0]    s_adr,
   output logic [SW-1:0]    s_sel,
   output logic [DW-1:0]    s_dat_w,
   input  logic [DW-1:0]    s_dat_r,
   input  logic             s_ack,
   input  logic             s_err,
   output logic [GW-1:0]    gnt,
   output logic             busy
);

   localparam int NP = 1 << GW;

   arb_state_t    state_reg;
   logic [GW-1:0] gnt_reg;
   logic [GW-1:0] last_reg;
   logic          busy_reg;
   logic [MN-1:0] mask_reg;

   logic [MN-1:0] req;
   logic [GW-1:0] pick_winner;
   logic          pick_valid;
   logic          rr_en;
   logic          done;

   // Per-master views of the flattened buses, padded to a power of two so
   // the grant index can select them directly.
   logic          we_arr  [NP];
   logic [AW-1:0] adr_arr [NP];
   logic [SW-1:0] sel_arr [NP];
   logic [DW-1:0] dat_arr [NP];

`ifdef QMEM_ARB_RR_EN
   assign rr_en = 1'b1;
`else
   assign rr_en = 1'b0;
`endif

   // The just-finished master is masked for the single idle cycle after its
   // ack, since it may still hold cs while it sees the ack.
   assign req  = m_cs & ~mask_reg;
   assign done = s_ack | s_err;

   qmem_arb_pick #(
      .MN (MN),
      .GW (GW)
   ) u_pick (
      .req    (req),
      .last   (last_reg),
      .rr_en  (rr_en),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_unpack
         if (gi < MN) begin : g_real
            assign we_arr[gi]  = m_we[gi];
            assign adr_arr[gi] = m_adr[gi*AW +: AW];
            assign sel_arr[gi] = m_sel[gi*SW +: SW];
            assign dat_arr[gi] = m_dat_w[gi*DW +: DW];
         end else begin : g_pad
            assign we_arr[gi]  = 1'b0;
            assign adr_arr[gi] = '0;
            assign sel_arr[gi] = '0;
            assign dat_arr[gi] = '0;
         end
      end

      // Responses go straight through to the granted master, only while a
      // transfer is active; anything arriving in idle is dropped.
      for (gi = 0; gi < MN; gi++) begin : g_resp
         assign m_ack[gi] = s_ack & busy_reg & (gnt_reg == GW'(gi));
         assign m_err[gi] = s_err & busy_reg & (gnt_reg == GW'(gi));
      end
   endgenerate

   // Arbiter FSM. busy_reg mirrors state_reg == ST_BUSY and drives s_cs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= '0;
         last_reg  <= '0;
         busy_reg  <= 1'b0;
         mask_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               mask_reg <= '0;
               if (pick_valid) begin
                  gnt_reg   <= pick_winner;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A cs drop by the granted master cannot cancel the slave
               // access, so only the slave response ends the transfer.
               if (done) begin
                  last_reg  <= gnt_reg;
                  mask_reg  <= {{(MN-1){1'b0}}, 1'b1} << gnt_reg;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Slave request mux; address/sel/data follow the grant even when idle.
   assign s_cs    = busy_reg;
   assign s_we    = busy_reg & we_arr[gnt_reg];
   assign s_adr   = adr_arr[gnt_reg];
   assign s_sel   = sel_arr[gnt_reg];
   assign s_dat_w = dat_arr[gnt_reg];

   assign m_dat_r = s_dat_r;
   assign gnt     = gnt_reg;
   assign busy    = busy_reg;

endmodule : qmem_arbiter

// File: tb/tb_qmem_arbiter.sv
module tb_qmem_arbiter;

   localparam int MN = 4;
   localparam int AW = 22;
   localparam int SW = 4;
   localparam int DW = 32;
   localparam int GW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [MN-1:0]    m_cs;
   logic [MN-1:0]    m_we;
   logic [MN*AW-1:0] m_adr;
   logic [MN*SW-1:0] m_sel;
   logic [MN*DW-1:0] m_dat_w;
   logic [DW-1:0]    m_dat_r;
   logic [MN-1:0]    m_ack;
   logic [MN-1:0]    m_err;
   logic             s_cs;
   logic             s_we;
   logic [AW-1:0]    s_adr;
   logic [SW-1:0]    s_sel;
   logic [DW-1:0]    s_dat_w;
   logic [DW-1:0]    s_dat_r;
   logic             s_ack;
   logic             s_err;
   logic [GW-1:0]    gnt;
   logic             busy;

   logic [AW-1:0] adr_tb [MN];
   logic [SW-1:0] sel_tb [MN];
   logic [DW-1:0] dat_tb [MN];

   typedef struct {
      int            g;
      logic [AW-1:0] adr;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;
      logic          we;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   ack_cnt [MN];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < MN; i++) begin
         m_adr[i*AW +: AW]   = adr_tb[i];
         m_sel[i*SW +: SW]   = sel_tb[i];
         m_dat_w[i*DW +: DW] = dat_tb[i];
      end
   end

   qmem_arbiter #(
      .MN (MN), .AW (AW), .SW (SW), .DW (DW), .GW (GW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_cs    (m_cs),
      .m_we    (m_we),
      .m_adr   (m_adr),
      .m_sel   (m_sel),
      .m_dat_w (m_dat_w),
      .m_dat_r (m_dat_r),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_cs    (s_cs),
      .s_we    (s_we),
      .s_adr   (s_adr),
      .s_sel   (s_sel),
      .s_dat_w (s_dat_w),
      .s_dat_r (s_dat_r),
      .s_ack   (s_ack),
      .s_err   (s_err),
      .gnt     (gnt),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int g);
      exp_t e;
      e.g   = g;
      e.adr = adr_tb[g];
      e.sel = sel_tb[g];
      e.dat = dat_tb[g];
      e.we  = m_we[g];
      sb.push_back(e);
   endtask

   // Slave model: wait for the grant, hold for wait_cyc cycles with s_cs
   // high, respond in the last of them, then check the idle gap.
   task automatic serve(input int wait_cyc, input bit err, input logic [DW-1:0] rdata,
                        input bit drop);
      exp_t          e;
      int            n;
      logic [MN-1:0] oh;
      n = 0;
      while (s_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("latency", n, 1);
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      oh = '0;
      oh[e.g] = 1'b1;
      chk("gnt", gnt, e.g);
      chk("busy", busy, 1);
      chk("s_adr", s_adr, e.adr);
      chk("s_sel", s_sel, e.sel);
      chk("s_dat_w", s_dat_w, e.dat);
      chk("s_we", s_we, e.we);
      for (int i = 1; i < wait_cyc; i++) begin
         chk("m_ack_early", m_ack, 0);
         @(negedge clk);
         #1;
         chk("s_cs_hold", s_cs, 1);
         chk("gnt_hold", gnt, e.g);
      end
      s_ack   = ~err;
      s_err   = err;
      s_dat_r = rdata;
      #1;
      chk("m_ack", m_ack, err ? '0 : oh);
      chk("m_err", m_err, err ? oh : '0);
      chk("m_dat_r", m_dat_r, rdata);
      for (int i = 0; i < MN; i++) ack_cnt[i] += int'(m_ack[i]);
      $display("xfer gnt=%0d adr=%h we=%b err=%b rdata=%h", e.g, s_adr, s_we, err, m_dat_r);
      @(negedge clk);
      s_ack = 1'b0;
      s_err = 1'b0;
      if (drop) m_cs[e.g] = 1'b0;
      #1;
      chk("s_cs_idle", s_cs, 0);
      chk("busy_idle", busy, 0);
      chk("m_ack_after", m_ack, 0);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      m_cs    = '0;
      m_we    = '0;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_dat_r = '0;
      adr_tb[0] = 22'h011110; adr_tb[1] = 22'h022220;
      adr_tb[2] = 22'h0A55A4; adr_tb[3] = 22'h033330;
      sel_tb[0] = 4'h1; sel_tb[1] = 4'h3; sel_tb[2] = 4'hF; sel_tb[3] = 4'hC;
      dat_tb[0] = 32'h00000A00; dat_tb[1] = 32'h11111B11;
      dat_tb[2] = 32'h22222C22; dat_tb[3] = 32'h33333D33;
      for (int i = 0; i < MN; i++) ack_cnt[i] = 0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_cs", s_cs, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_m_ack", m_ack, 0);
      chk("rst_m_err", m_err, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Single master 2 write, 5-cycle slave.
      @(negedge clk);
      m_we[2] = 1'b1;
      m_cs    = 4'b0100;
      push(2);
      #1;
      chk("s_cs_same_cycle", s_cs, 0);
      serve(5, 1'b0, 32'h0, 1'b1);

      // Three simultaneous requesters, each drops cs after its ack.
      @(negedge clk);
      m_we = 4'b1011;
      m_cs = 4'b1011;
`ifdef QMEM_ARB_RR_EN
      push(3); push(0); push(1);
`else
      push(0); push(1); push(3);
`endif
      #1;
      serve(2, 1'b0, 32'h0, 1'b1);
      serve(3, 1'b0, 32'h0, 1'b1);
      serve(1, 1'b0, 32'h0, 1'b1);

      // Read by master 1.
      @(negedge clk);
      m_we = '0;
      m_cs = 4'b0010;
      push(1);
      #1;
      serve(2, 1'b0, 32'hDEADBEEF, 1'b1);

      // Error response to master 3, then a stray ack while idle.
      @(negedge clk);
      m_we[3] = 1'b1;
      m_cs    = 4'b1000;
      push(3);
      #1;
      serve(3, 1'b1, 32'h0, 1'b1);
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      chk("stray_m_ack", m_ack, 0);
      chk("stray_m_err", m_err, 0);
      chk("stray_busy", busy, 0);
      @(negedge clk);
      s_ack = 1'b0;

      // All four masters keep requesting for eight transfers.
      for (int i = 0; i < MN; i++) ack_cnt[i] = 0;
      m_we = 4'b0101;
      m_cs = 4'b1111;
      for (int k = 0; k < 8; k++) begin
`ifdef QMEM_ARB_RR_EN
         push(k % 4);
`else
         push(k % 2);
`endif
      end
      #1;
      for (int k = 0; k < 8; k++) begin
         serve(1 + (k % 3), 1'b0, 32'h1000 + k, 1'b0);
      end
      m_cs = '0;
`ifdef QMEM_ARB_RR_EN
      for (int i = 0; i < MN; i++) chk($sformatf("rr_count%0d", i), ack_cnt[i], 2);
`else
      chk("fp_count0", ack_cnt[0], 4);
      chk("fp_count1", ack_cnt[1], 4);
      chk("fp_count2", ack_cnt[2], 0);
      chk("fp_count3", ack_cnt[3], 0);
`endif

      // Reset in the middle of a transfer by master 2.
      @(negedge clk);
      m_we = '0;
      m_cs = 4'b0100;
      #1;
      n = 0;
      while (s_cs !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("rst_mid_grant", gnt, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      m_cs = '0;
      #1;
      chk("rst_mid_s_cs", s_cs, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_gnt", gnt, 0);
      s_ack = 1'b1;
      #1;
      chk("rst_late_ack", m_ack, 0);
      @(negedge clk);
      s_ack = 1'b0;
      #1;

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule : tb_qmem_arbiter

// File: doc/qmem_arbiter.md
Name: qmem_arbiter

Overview:
- N-master to 1-slave QMEM arbiter, single clock domain.
- Shares one QMEM slave port between up to 8 requesters, e.g. CPU data, CPU instruction and OSD/SPI masters all reaching the 32-to-16 async bridge master port.
- Grant is held for a whole transfer, from request until slave ack/err.
- Priority is fixed by default; round-robin is a build option.

Parameters:
- MN, 4: number of masters, 2..8.
- AW, 22: address width.
- SW, 4: byte-select width.
- DW, 32: data width.
- GW, 2: grant index width; must equal clog2(MN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_cs  in  MN  per-master request.
- m_we  in  MN  per-master write enable.
- m_adr  in  MN*AW  flattened addresses; master i occupies [i*AW +: AW].
- m_sel  in  MN*SW  flattened byte selects.
- m_dat_w  in  MN*DW  flattened write data.
- m_dat_r  out  DW  read data, broadcast to all masters.
- m_ack  out  MN  per-master ack.
- m_err  out  MN  per-master err.
- s_cs  out  1  slave chip select.
- s_we  out  1  slave write enable.
- s_adr  out  AW  slave address.
- s_sel  out  SW  slave byte selects.
- s_dat_w  out  DW  slave write data.
- s_dat_r  in  DW  slave read data.
- s_ack  in  1  slave ack.
- s_err  in  1  slave err.
- gnt  out  GW  current grant index, for debug.
- busy  out  1  transfer in progress.

Behaviour:
- Reset: state=ST_IDLE, gnt=0, busy=0, last=0, mask=0; s_cs=0; all m_ack/m_err=0. Reset mid-transfer drops s_cs on the next edge and discards any pending slave ack.
- States: ST_IDLE, ST_BUSY.
- Masters hold cs/we/adr/sel/dat_w stable from cs rise until their ack/err.
- ST_IDLE: req = m_cs & ~mask.
  - If req != 0: pick the winner, register gnt=winner, go to ST_BUSY, set busy=1.
  - mask is cleared every IDLE cycle.
- ST_BUSY:
  - s_cs=1.
  - s_we/s_adr/s_sel/s_dat_w are combinational muxes of master gnt's inputs.
  - On s_ack|s_err: go to ST_IDLE, set busy=0, last=gnt, mask=onehot(gnt) for exactly one cycle. The mask blocks re-grant to the master whose cs is still high the cycle after its ack.
- Latency:
  - Request seen in IDLE → s_cs high the next cycle.
  - Back-to-back transfers from different masters have one idle cycle between them.
  - Back-to-back from the same master: the master must deassert cs first.
- Response routing:
  - m_ack[i] = s_ack & busy & (gnt==i); m_err is the same with s_err. Both are combinational with zero added latency.
  - m_dat_r = s_dat_r, unregistered.
  - Ack/err arriving in ST_IDLE is ignored.
  - Simultaneous s_ack and s_err: both are forwarded; the FSM leaves BUSY.
- Mid-transfer cs drop by the granted master is a protocol violation. The grant is still held until s_ack/s_err, because the slave transaction cannot be cancelled. Other masters' cs changes do not affect the active transfer.
- Fixed priority: lowest index wins.
- Outputs when ST_IDLE: s_cs=0; s_we=0; s_adr/s_sel/s_dat_w follow master gnt (don't-care).

Optional Feature:
- QMEM_ARB_RR_EN defined:
  - Round-robin; the search starts at (last+1) mod MN and wraps.
  - last updates only on a completed transfer.
  - MN not a power of 2: indices ≥ MN are skipped.
- QMEM_ARB_RR_EN undefined: fixed priority; last still updates but is unused.

Decomposition:
- Shared package qmem_arb_pkg:
  - State localparams ST_IDLE=1'b0, ST_BUSY=1'b1.
  - QMEM default widths: 22/4/32.
- Sub-module qmem_arb_pick:
  - Purely combinational MN-input picker.
  - Inputs: req, last, rr_en.
  - Outputs: winner index, valid.

Test Plan:
- Single master 2 with MN=4: m_cs=4'b0100, adr=22'h0A55A4, write, sel=4'hF; slave acks after 5 cycles.
  - Required: s_cs rises 1 cycle after m_cs and stays high 5 cycles with s_adr=22'h0A55A4.
  - Required: m_ack=4'b0100 for exactly 1 cycle; m_err=0.
- Fixed priority, m_cs=4'b1011 at once, each master drops cs the cycle after its ack.
  - Required: grant order 0,1,3, with one idle cycle between transfers.
- Build with QMEM_ARB_RR_EN, all 4 masters continuously re-requesting, 8 transfers.
  - Required: grant sequence 0,1,2,3,0,1,2,3.
  - Required: no master is starved; each completes 2 transfers.
- Read path, master 1 reads, slave returns s_dat_r=32'hDEADBEEF with s_ack.
  - Required: m_dat_r=32'hDEADBEEF in the same cycle as m_ack[1].
  - Required: m_ack[0], m_ack[2] and m_ack[3] stay 0.
- Error path, slave asserts s_err for master 3.
  - Required: m_err=4'b1000 for 1 cycle and the FSM returns to IDLE.
  - Required: a stray s_ack in IDLE produces m_ack=0.
- Reset while BUSY: assert rst for 1 cycle mid-transfer.
  - Required: s_cs=0, busy=0 and gnt=0 on the next cycle.
  - Required: an ack arriving afterwards produces no m_ack.
